// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_pkg : shared encodings for core memory requests               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package core_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_dir_e;

    // funct3-style access size; unlisted codes are illegal
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_size_e;

    typedef enum logic [1:0] {
        RSV_NONE  = 2'd0,
        RSV_SET   = 2'd1,
        RSV_CLEAR = 2'd2
    } mem_rsv_e;

endpackage
`default_nettype wire

// File: rtl/core_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_mem_responder_if : core request/response and downstream bus   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface core_mem_responder_if;
    import core_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    mem_dir_e    req_dir;
    mem_size_e   req_size;
    mem_rsv_e    req_rsv;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    // responder side
    modport slave (
        input  req_valid, req_addr, req_dir, req_size, req_rsv, req_wdata,
        input  resp_ready, bus_ready, bus_rvalid, bus_rdata, bus_err,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
    );

    // core plus downstream memory side
    modport master (
        output req_valid, req_addr, req_dir, req_size, req_rsv, req_wdata,
        output resp_ready, bus_ready, bus_rvalid, bus_rdata, bus_err,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
    );

endinterface
`default_nettype wire

// File: rtl/core_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_mem_responder : single-outstanding load/store/LR/SC responder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module core_mem_responder
    import core_pkg::*;
#(
    parameter int RSV_GRAN_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rsv_clear,
    core_mem_responder_if.slave  io
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUS_REQ  = 2'd1,
        S_BUS_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    state_e                   state_q,      state_d;
    logic                     req_ready_q,  req_ready_d;
    logic [31:0]              addr_q,       addr_d;
    mem_dir_e                 dir_q,        dir_d;
    mem_size_e                size_q,       size_d;
    mem_rsv_e                 rsv_q,        rsv_d;
    logic                     bus_valid_q,  bus_valid_d;
    logic [31:0]              bus_addr_q,   bus_addr_d;
    logic                     bus_we_q,     bus_we_d;
    logic [3:0]               bus_wstrb_q,  bus_wstrb_d;
    logic [31:0]              bus_wdata_q,  bus_wdata_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [31:0]              resp_rdata_q, resp_rdata_d;
    logic                     resp_err_q,   resp_err_d;
    logic                     rsv_valid_q,  rsv_valid_d;
    logic [31-RSV_GRAN_BITS:0] rsv_gran_q,  rsv_gran_d;

    logic        w_accept;
    logic        w_bad_access;
    logic        w_is_sc;
    logic        w_gran_hit;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_accept   = io.req_valid & req_ready_q;
    assign w_is_sc    = (io.req_dir == MEM_WRITE) && (io.req_rsv == RSV_CLEAR);
    assign w_gran_hit = rsv_valid_q && (io.req_addr[31:RSV_GRAN_BITS] == rsv_gran_q);

    // Alignment/legality and store lane steering for the incoming request
    always_comb begin
        w_bad_access = 1'b0;
        w_strb       = 4'b0001 << io.req_addr[1:0];
        w_wdata      = {4{io.req_wdata[7:0]}};
        case (io.req_size)
            MEM_B, MEM_BU: w_bad_access = 1'b0;
            MEM_H, MEM_HU: begin
                w_bad_access = io.req_addr[0];
                w_strb       = io.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{io.req_wdata[15:0]}};
            end
            MEM_W: begin
                w_bad_access = |io.req_addr[1:0];
                w_strb       = 4'b1111;
                w_wdata      = io.req_wdata;
            end
            default: w_bad_access = 1'b1;
        endcase
    end

    assign w_shifted = io.bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            MEM_B:   w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_BU:  w_load_data = {24'b0, w_shifted[7:0]};
            MEM_H:   w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_HU:  w_load_data = {16'b0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        addr_d       = addr_q;
        dir_d        = dir_q;
        size_d       = size_q;
        rsv_d        = rsv_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_we_d     = bus_we_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_wdata_d  = bus_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        rsv_valid_d  = rsv_valid_q;
        rsv_gran_d   = rsv_gran_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    req_ready_d = 1'b0;
                    addr_d      = io.req_addr;
                    dir_d       = io.req_dir;
                    size_d      = io.req_size;
                    rsv_d       = io.req_rsv;
                    if (w_bad_access) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                        if (w_is_sc) rsv_valid_d = 1'b0;
                    end else if (w_is_sc && !w_gran_hit) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h1;
                        resp_err_d   = 1'b0;
                        rsv_valid_d  = 1'b0;
                    end else begin
                        state_d     = S_BUS_REQ;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = {io.req_addr[31:2], 2'b00};
                        bus_we_d    = (io.req_dir == MEM_WRITE);
                        bus_wstrb_d = (io.req_dir == MEM_WRITE) ? w_strb  : 4'b0;
                        bus_wdata_d = (io.req_dir == MEM_WRITE) ? w_wdata : 32'h0;
                    end
                end
            end
            S_BUS_REQ: begin
                if (io.bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = S_BUS_WAIT;
                end
            end
            S_BUS_WAIT: begin
                if (io.bus_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = io.bus_err;
                    if (dir_q == MEM_WRITE) begin
                        // SC reports failure as 1 even when the bus errors
                        resp_rdata_d = (rsv_q == RSV_CLEAR) ? {31'b0, io.bus_err} : 32'h0;
                        if ((rsv_q == RSV_CLEAR) ||
                            (rsv_valid_q && (addr_q[31:RSV_GRAN_BITS] == rsv_gran_q)))
                            rsv_valid_d = 1'b0;
                    end else begin
                        resp_rdata_d = io.bus_err ? 32'h0 : w_load_data;
                        if ((rsv_q == RSV_SET) && !io.bus_err) begin
                            rsv_valid_d = 1'b1;
                            rsv_gran_d  = addr_q[31:RSV_GRAN_BITS];
                        end
                    end
                end
            end
            S_RESP: begin
                if (io.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // external kill has the last word over any same-cycle LR set
        if (rsv_clear) rsv_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            addr_q       <= 32'h0;
            dir_q        <= MEM_READ;
            size_q       <= MEM_B;
            rsv_q        <= RSV_NONE;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_we_q     <= 1'b0;
            bus_wstrb_q  <= 4'b0;
            bus_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            rsv_valid_q  <= 1'b0;
            rsv_gran_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            addr_q       <= addr_d;
            dir_q        <= dir_d;
            size_q       <= size_d;
            rsv_q        <= rsv_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_we_q     <= bus_we_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            rsv_valid_q  <= rsv_valid_d;
            rsv_gran_q   <= rsv_gran_d;
        end
    end

    assign io.req_ready  = req_ready_q;
    assign io.bus_valid  = bus_valid_q;
    assign io.bus_addr   = bus_addr_q;
    assign io.bus_we     = bus_we_q;
    assign io.bus_wstrb  = bus_wstrb_q;
    assign io.bus_wdata  = bus_wdata_q;
    assign io.resp_valid = resp_valid_q;
    assign io.resp_rdata = resp_rdata_q;
    assign io.resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_core_mem_responder : randomized + directed bench with reference |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_core_mem_responder;
    import core_pkg::*;

    localparam int G = 2;

    logic clk;
    logic rst_n;
    logic rsv_clear;
    int   n_checks;
    int   n_pass;

    core_mem_responder_if io ();

    core_mem_responder #(.RSV_GRAN_BITS(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsv_clear (rsv_clear),
        .io        (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference reservation state
    logic        m_rsv_valid;
    logic [31:0] m_rsv_gran;

    // observations returned by run_txn
    logic        o_bus, o_we, o_err, o_stable, o_rr_low, o_rr_after, o_tmo;
    logic [31:0] o_baddr, o_bwd, o_rd;
    logic [3:0]  o_strb;
    int          o_lat;

    // expectations returned by model_txn
    logic        e_bus, e_err;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_rd;

    task automatic model_txn(input logic [31:0] a, input mem_dir_e d, input logic [2:0] s,
                             input mem_rsv_e r, input logic [31:0] wd, input logic [31:0] brd,
                             input logic be);
        int nbytes, off;
        logic sgn, sc;
        logic [63:0] v, mask;
        off = int'(a[1:0]);
        sgn = 1'b0;
        case (s)
            3'd0: begin nbytes = 1; sgn = 1'b1; end
            3'd1: begin nbytes = 2; sgn = 1'b1; end
            3'd2: nbytes = 4;
            3'd4: nbytes = 1;
            3'd5: nbytes = 2;
            default: nbytes = 0;
        endcase
        sc = (d == MEM_WRITE) && (r == RSV_CLEAR);
        e_bus = 0; e_strb = 0; e_wd = 0; e_rd = 0; e_err = 0;
        if (nbytes == 0 || (off % nbytes) != 0) begin
            e_err = 1;
            if (sc) m_rsv_valid = 0;
        end else if (sc && !(m_rsv_valid && m_rsv_gran == (a >> G))) begin
            e_rd = 1;
            m_rsv_valid = 0;
        end else begin
            e_bus = 1;
            if (d == MEM_WRITE) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= off && i < off + nbytes) e_strb[i] = 1'b1;
                    e_wd[8*i +: 8] = wd[8*(i % nbytes) +: 8];
                end
                e_err = be;
                e_rd  = sc ? {31'b0, be} : 32'h0;
                if (sc || (m_rsv_valid && m_rsv_gran == (a >> G))) m_rsv_valid = 0;
            end else if (be) begin
                e_err = 1;
            end else begin
                v    = {32'b0, brd} >> (8 * off);
                mask = (64'd1 << (8 * nbytes)) - 64'd1;
                v    = v & mask;
                if (sgn && v[8*nbytes-1]) v = v | ~mask;
                e_rd = v[31:0];
                if (r == RSV_SET) begin
                    m_rsv_valid = 1;
                    m_rsv_gran  = a >> G;
                end
            end
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input mem_dir_e d, input logic [2:0] s,
                           input mem_rsv_e r, input logic [31:0] wd, input logic [31:0] brd,
                           input logic be, input int bdly, input int rdly);
        int bw, rw;
        logic rv_pend, done;
        o_bus = 0; o_baddr = 0; o_we = 0; o_strb = 0; o_bwd = 0; o_rd = 0; o_err = 0;
        o_lat = -1; o_stable = 1; o_rr_low = 1; o_rr_after = 0; o_tmo = 0;
        bw = 0; rw = 0; rv_pend = 0; done = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && !io.req_ready; i++) @(negedge clk);
        io.req_valid = 1; io.req_addr = a; io.req_dir = d;
        io.req_size = mem_size_e'(s); io.req_rsv = r; io.req_wdata = wd;
        @(posedge clk);
        #1;
        io.req_valid = 0; io.req_addr = $urandom; io.req_wdata = $urandom;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            io.bus_ready = 0; io.bus_rvalid = 0; io.resp_ready = 0;
            io.bus_rdata = $urandom; io.bus_err = 1'($urandom);
            if (io.req_ready) o_rr_low = 0;
            if (rv_pend) begin
                io.bus_rvalid = 1; io.bus_rdata = brd; io.bus_err = be; rv_pend = 0;
            end
            if (io.bus_valid) begin
                if (!o_bus) begin
                    o_bus = 1; o_baddr = io.bus_addr; o_we = io.bus_we;
                    o_strb = io.bus_wstrb; o_bwd = io.bus_wdata;
                end else if ({io.bus_addr, io.bus_we, io.bus_wstrb, io.bus_wdata} !==
                             {o_baddr, o_we, o_strb, o_bwd}) o_stable = 0;
                if (bw >= bdly) begin io.bus_ready = 1; rv_pend = 1; end
                else bw++;
            end
            if (io.resp_valid) begin
                if (o_lat < 0) begin
                    o_lat = cyc; o_rd = io.resp_rdata; o_err = io.resp_err;
                end else if ({io.resp_rdata, io.resp_err} !== {o_rd, o_err}) o_stable = 0;
                if (rw >= rdly) begin io.resp_ready = 1; done = 1; end
                else rw++;
            end
        end
        if (!done) o_tmo = 1;
        @(negedge clk);
        io.resp_ready = 0; io.bus_ready = 0; io.bus_rvalid = 0;
        o_rr_after = io.req_ready;
    endtask

    task automatic test_reset();
        rst_n = 0; rsv_clear = 0;
        io.req_valid = 0; io.req_addr = 0; io.req_dir = MEM_READ; io.req_size = MEM_B;
        io.req_rsv = RSV_NONE; io.req_wdata = 0; io.resp_ready = 0; io.bus_ready = 0;
        io.bus_rvalid = 0; io.bus_rdata = 0; io.bus_err = 0;
        m_rsv_valid = 0; m_rsv_gran = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({io.req_ready, io.resp_valid, io.resp_rdata, io.resp_err, io.bus_valid,
                 io.bus_we, io.bus_wstrb, io.bus_addr, io.bus_wdata} !== {1'b1, 104'b0})
                $display("FAIL reset_outputs[%0d]: req_ready=%b resp_valid=%b rdata=%h err=%b bus_valid=%b we=%b strb=%b addr=%h wdata=%h want ready=1 rest 0",
                         k, io.req_ready, io.resp_valid, io.resp_rdata, io.resp_err, io.bus_valid,
                         io.bus_we, io.bus_wstrb, io.bus_addr, io.bus_wdata);
            else n_pass++;
            rst_n = 1;
            @(negedge clk);
        end
    endtask

    task automatic test_directed();
        // signed byte load from the top lane
        model_txn(32'h1003, MEM_READ, 3'd0, RSV_NONE, 0, 32'h80AA_BBCC, 0);
        run_txn(32'h1003, MEM_READ, 3'd0, RSV_NONE, 0, 32'h80AA_BBCC, 0, 0, 0);
        n_checks++; if (o_baddr !== 32'h1000) $display("FAIL lb_addr: got %h want 00001000", o_baddr); else n_pass++;
        n_checks++; if ({o_rd, o_err} !== {32'hFFFF_FF80, 1'b0}) $display("FAIL lb_data: got %h/%b want ffffff80/0", o_rd, o_err); else n_pass++;
        n_checks++; if (o_lat !== 3) $display("FAIL lb_latency: got %0d want 3", o_lat); else n_pass++;

        model_txn(32'h2002, MEM_WRITE, 3'd1, RSV_NONE, 32'h1234, 0, 0);
        run_txn(32'h2002, MEM_WRITE, 3'd1, RSV_NONE, 32'h0000_1234, 0, 0, 0, 0);
        n_checks++; if ({o_we, o_strb, o_bwd, o_rd} !== {1'b1, 4'b1100, 32'h1234_1234, 32'h0})
            $display("FAIL sh_payload: we=%b strb=%b wdata=%h rdata=%h want 1/1100/12341234/0", o_we, o_strb, o_bwd, o_rd); else n_pass++;

        model_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 32'h5, 0);
        run_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 32'h5, 0, 0, 0);
        model_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 32'hAB, 0, 0);
        run_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 32'hAB, 0, 0, 0, 0);
        n_checks++; if ({o_bus, o_we, o_rd} !== {2'b11, 32'h0}) $display("FAIL sc_pass: bus=%b we=%b rdata=%h want 1/1/0", o_bus, o_we, o_rd); else n_pass++;
        model_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 32'hAB, 0, 0);
        run_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 32'hAB, 0, 0, 0, 0);
        n_checks++; if ({o_bus, o_rd, o_lat} !== {1'b0, 32'h1, 32'd1}) $display("FAIL sc_again: bus=%b rdata=%h lat=%0d want 0/1/1", o_bus, o_rd, o_lat); else n_pass++;

        model_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 0, 0);
        run_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 0, 0, 0, 0);
        @(negedge clk); rsv_clear = 1; @(negedge clk); rsv_clear = 0; m_rsv_valid = 0;
        model_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 1, 0, 0);
        run_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 1, 0, 0, 0, 0);
        n_checks++; if ({o_bus, o_rd} !== {1'b0, 32'h1}) $display("FAIL sc_after_kill: bus=%b rdata=%h want 0/1", o_bus, o_rd); else n_pass++;

        model_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 0, 0);
        run_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 0, 0, 0, 0);
        model_txn(32'h3000, MEM_WRITE, 3'd2, RSV_NONE, 7, 0, 0);
        run_txn(32'h3000, MEM_WRITE, 3'd2, RSV_NONE, 7, 0, 0, 0, 0);
        model_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 1, 0, 0);
        run_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 1, 0, 0, 0, 0);
        n_checks++; if ({o_bus, o_rd} !== {1'b0, 32'h1}) $display("FAIL sc_after_sw: bus=%b rdata=%h want 0/1", o_bus, o_rd); else n_pass++;

        model_txn(32'h4002, MEM_READ, 3'd2, RSV_NONE, 0, 0, 0);
        run_txn(32'h4002, MEM_READ, 3'd2, RSV_NONE, 0, 0, 0, 0, 0);
        n_checks++; if ({o_bus, o_err, o_rd, o_lat} !== {2'b01, 32'h0, 32'd1}) $display("FAIL lw_misaligned: bus=%b err=%b rdata=%h lat=%0d want 0/1/0/1", o_bus, o_err, o_rd, o_lat); else n_pass++;
        model_txn(32'h4000, MEM_READ, 3'd2, RSV_NONE, 0, 32'hDEAD_BEEF, 1);
        run_txn(32'h4000, MEM_READ, 3'd2, RSV_NONE, 0, 32'hDEAD_BEEF, 1, 0, 0);
        n_checks++; if ({o_err, o_rd} !== {1'b1, 32'h0}) $display("FAIL lw_bus_err: err=%b rdata=%h want 1/0", o_err, o_rd); else n_pass++;
    endtask

    task automatic test_stall();
        model_txn(32'h6004, MEM_WRITE, 3'd0, RSV_NONE, 32'h77, 0, 0);
        run_txn(32'h6005, MEM_WRITE, 3'd0, RSV_NONE, 32'hA5, 0, 0, 5, 3);
        n_checks++; if (o_stable !== 1'b1) $display("FAIL stall_stable: got %b want 1", o_stable); else n_pass++;
        n_checks++; if (o_rr_low !== 1'b1) $display("FAIL stall_req_ready_low: got %b want 1", o_rr_low); else n_pass++;
        n_checks++; if (o_lat !== 8) $display("FAIL stall_latency: got %0d want 8", o_lat); else n_pass++;
        n_checks++; if ({o_strb, o_bwd, o_rr_after} !== {4'b0010, 32'hA5A5_A5A5, 1'b1})
            $display("FAIL stall_payload: strb=%b wdata=%h ready_after=%b want 0010/a5a5a5a5/1", o_strb, o_bwd, o_rr_after); else n_pass++;
    endtask

    task automatic test_reset_mid();
        model_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 0, 0);
        run_txn(32'h3000, MEM_READ, 3'd2, RSV_SET, 0, 0, 0, 0, 0);
        @(negedge clk);
        io.req_valid = 1; io.req_addr = 32'h5000; io.req_dir = MEM_READ;
        io.req_size = MEM_W; io.req_rsv = RSV_NONE;
        @(posedge clk); #1 io.req_valid = 0;
        @(negedge clk);
        n_checks++; if (io.bus_valid !== 1'b1) $display("FAIL mid_bus_valid: got %b want 1", io.bus_valid); else n_pass++;
        io.bus_ready = 1;
        @(negedge clk); io.bus_ready = 0;
        #2 rst_n = 0;
        #1;
        n_checks++; if ({io.req_ready, io.bus_valid, io.resp_valid} !== 3'b100)
            $display("FAIL mid_async_reset: ready=%b bus_valid=%b resp_valid=%b want 1/0/0", io.req_ready, io.bus_valid, io.resp_valid); else n_pass++;
        @(negedge clk); rst_n = 1; m_rsv_valid = 0;
        io.bus_rvalid = 1; io.bus_rdata = 32'h1234_5678; io.bus_err = 0;
        @(negedge clk); io.bus_rvalid = 0;
        n_checks++; if ({io.resp_valid, io.req_ready} !== 2'b01) $display("FAIL mid_late_rvalid: resp_valid=%b ready=%b want 0/1", io.resp_valid, io.req_ready); else n_pass++;
        model_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 1, 0, 0);
        run_txn(32'h3000, MEM_WRITE, 3'd2, RSV_CLEAR, 1, 0, 0, 0, 0);
        n_checks++; if ({o_bus, o_rd} !== {1'b0, 32'h1}) $display("FAIL mid_rsv_invalid: bus=%b rdata=%h want 0/1", o_bus, o_rd); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, wd, brd;
        logic [2:0]  s;
        logic        be;
        mem_dir_e    d;
        mem_rsv_e    r;
        int          kind, bdly, exp_lat;
        logic [2:0]  ld_sizes [5];
        logic [2:0]  bad_sizes [3];
        ld_sizes  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bad_sizes = '{3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            a    = 32'h3000 + 4 * $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = a + $urandom_range(0, 3);
            wd = $urandom; brd = $urandom;
            be = ($urandom_range(0, 7) == 0);
            bdly = $urandom_range(0, 2);
            d = (kind == 1 || kind == 3) ? MEM_WRITE : MEM_READ;
            r = (kind == 2) ? RSV_SET : (kind == 3) ? RSV_CLEAR : RSV_NONE;
            if (kind >= 2) s = 3'd2;
            else if (kind == 0) s = ld_sizes[$urandom_range(0, 4)];
            else s = ld_sizes[$urandom_range(0, 2)];
            if ($urandom_range(0, 9) == 0) s = bad_sizes[$urandom_range(0, 2)];
            model_txn(a, d, s, r, wd, brd, be);
            run_txn(a, d, s, r, wd, brd, be, bdly, $urandom_range(0, 2));
            exp_lat = e_bus ? 3 + bdly : 1;
            n_checks++; if (o_tmo !== 1'b0) $display("FAIL rnd%0d_timeout", n); else n_pass++;
            n_checks++; if (o_bus !== e_bus) $display("FAIL rnd%0d_bus: got %b want %b", n, o_bus, e_bus); else n_pass++;
            n_checks++; if (o_lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", n, o_lat, exp_lat); else n_pass++;
            n_checks++; if ({o_rd, o_err} !== {e_rd, e_err}) $display("FAIL rnd%0d_resp: got %h/%b want %h/%b", n, o_rd, o_err, e_rd, e_err); else n_pass++;
            if (e_bus) begin
                n_checks++; if ({o_baddr, o_we} !== {a & 32'hFFFF_FFFC, d == MEM_WRITE})
                    $display("FAIL rnd%0d_addr: got %h/%b want %h", n, o_baddr, o_we, a & 32'hFFFF_FFFC); else n_pass++;
                if (d == MEM_WRITE) begin
                    n_checks++; if ({o_strb, o_bwd} !== {e_strb, e_wd})
                        $display("FAIL rnd%0d_wr: got %b/%h want %b/%h", n, o_strb, o_bwd, e_strb, e_wd); else n_pass++;
                end
            end
            n_checks++; if ({o_rr_low, o_rr_after, o_stable} !== 3'b111)
                $display("FAIL rnd%0d_handshake: got %b want 111", n, {o_rr_low, o_rr_after, o_stable}); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_mem_responder.md
CORE_MEM_RESPONDER -- requirements
Module: core_mem_responder

Interface
REQ-001 Parameter RSV_GRAN_BITS, default 2, log2 of reservation granule in bytes; legal range 2..6.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  core memory request present.
REQ-005 req_ready  out  1  block accepts request (high only in IDLE).
REQ-006 req_addr  in  32  byte address.
REQ-007 req_dir  in  core_pkg::mem_dir_e  MEM_READ or MEM_WRITE.
REQ-008 req_size  in  core_pkg::mem_size_e  funct3 encoding: 0=B, 1=H, 2=W, 4=BU, 5=HU; others illegal.
REQ-009 req_rsv  in  core_pkg::mem_rsv_e  RSV_NONE, RSV_SET (LR), RSV_CLEAR (SC).
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-012 resp_rdata  out  32  load data, extended; SC result (0 success, 1 fail).
REQ-013 resp_err  out  1  misaligned, illegal size or bus error.
REQ-014 bus_valid / bus_ready  out / in  1 / 1  downstream request handshake.
REQ-015 bus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00}).
REQ-016 bus_we, bus_wstrb, bus_wdata  out  1, 4, 32  write enable, byte strobes, lane-replicated data.
REQ-017 bus_rvalid, bus_rdata, bus_err  in  1, 32, 1  downstream response.
REQ-018 rsv_clear  in  1  external reservation kill (trap, context switch).

Function
REQ-019 States IDLE, BUS_REQ, BUS_WAIT, RESP; one request outstanding; all request fields captured at accept (req_valid & req_ready).
REQ-020 Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal size: IDLE -> RESP, no bus access, resp_err=1, resp_rdata=0.
REQ-021 SC (write, RSV_CLEAR) with reservation invalid or granule mismatch (addr[31:RSV_GRAN_BITS]): IDLE -> RESP, no bus access, resp_rdata=1, resp_err=0.
REQ-022 Any other accepted request: IDLE -> BUS_REQ; bus_valid asserted cycle after accept.
REQ-023 BUS_REQ: bus_valid high, payload stable until bus_ready; on bus_ready -> BUS_WAIT.
REQ-024 BUS_WAIT: bus_rvalid sampled only here (earliest one cycle after bus handshake); on bus_rvalid -> RESP.
REQ-025 Write strobes: B -> 1 lane at addr[1:0]; H -> 2 lanes at addr[1]; W -> 4'b1111; bus_wdata replicates byte/half across lanes.
REQ-026 Read data: shift bus_rdata right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-027 Store response: resp_rdata=0; SC success resp_rdata=0.
REQ-028 bus_err=1: resp_err=1, resp_rdata=0, except SC which returns resp_rdata=1.
REQ-029 RESP: resp_valid high, outputs stable until resp_ready; then IDLE; req_ready high in that IDLE cycle at earliest (no same-cycle reaccept).
REQ-030 Reservation set at LR bus completion without bus_err: valid=1, granule=addr[31:RSV_GRAN_BITS].
REQ-031 Reservation cleared by: any SC completion (pass, fail, error); any non-SC store completing to reserved granule; rsv_clear.
REQ-032 rsv_clear simultaneous with LR set: clear wins; reservation invalid.
REQ-033 LR with bus_err or misalignment leaves reservation unchanged.
REQ-034 Latency: load/store/LR/successful SC with zero-wait bus = accept N, bus_valid N+1, bus_ready N+1, bus_rvalid N+2, resp_valid N+3; local fail/error resp_valid N+1.

Reset
REQ-035 rst_n low asynchronously forces IDLE, reservation invalid, captured fields 0.
REQ-036 During and after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bus_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0.
REQ-037 Reset mid-transaction abandons it; late bus_rvalid after reset is ignored (not in BUS_WAIT).

Verification
REQ-038 LB addr 0x1003, bus_rdata 0x80AA_BBCC -> bus_addr 0x1000, resp_rdata 0xFFFF_FF80, resp_err=0.
REQ-039 SH addr 0x2002, wdata 0x0000_1234 -> bus_wstrb 4'b1100, bus_wdata 0x1234_1234, resp_rdata 0.
REQ-040 LR 0x3000 then SC 0x3000 -> SC bus write issued, resp_rdata 0; second SC 0x3000 -> no bus_valid, resp_rdata 1.
REQ-041 LR 0x3000, rsv_clear pulse, SC 0x3000 -> no bus access, resp_rdata 1; also LR 0x3000 then SW 0x3000 then SC -> resp_rdata 1.
REQ-042 LW addr 0x4002 -> no bus_valid, resp_err=1 cycle after accept; LW with bus_err -> resp_err=1, resp_rdata 0.
REQ-043 bus_ready held low 5 cycles and resp_ready held low 3 cycles -> payloads stable, req_ready low throughout; rst_n pulse in BUS_WAIT -> IDLE, reservation invalid.
